// File: rtl/sync_fifo_status.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/almost-empty
// compares, sticky overflow/underflow flags and flush. Optional FIFO_WATERMARK_EN.
module sync_fifo_status #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  input  logic [CNT_W-1:0]  af_thresh_i,
  input  logic [CNT_W-1:0]  ae_thresh_i,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic [CNT_W-1:0]  max_count_o
);

  localparam int IDX_W = CNT_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_push_acc;
  logic              w_pop_acc;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

  // Wrap bits differ with equal indices means the writer is a full lap ahead.
  assign w_full  = (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]) && (w_wr_idx == w_rd_idx);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_push_acc = push_i && (!w_full || pop_i);
  assign w_pop_acc  = pop_i && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop_acc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop_acc && !w_push_acc) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end
      r_count <= w_count_nxt;
      if (push_i && w_full && !pop_i) begin
        r_overflow <= 1'b1;
      end
      if (pop_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; a flush or reset must not write a pending push.
  always_ff @(posedge clk) begin
    if (!reset && !clear_i && w_push_acc) begin
      r_mem[w_wr_idx] <= push_data_i;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic [CNT_W-1:0] r_max_count;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      r_max_count <= '0;
    end else if (w_count_nxt > r_max_count) begin
      r_max_count <= w_count_nxt;
    end
  end

  assign max_count_o = r_max_count;
`else
  assign max_count_o = '0;
`endif

  assign pop_data_o     = w_empty ? '0 : r_mem[w_rd_idx];
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign count_o        = r_count;
  assign almost_full_o  = (r_count >= af_thresh_i);
  assign almost_empty_o = (r_count <= ae_thresh_i);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_status.sv
// Bench for sync_fifo_status (DEPTH=4, DATA_W=8): directed vector table,
// threshold sequence, then random traffic against a queue-based model.
module tb_sync_fifo_status;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;
`ifdef FIFO_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              clear_i;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic [CNT_W-1:0]  af_thresh_i;
  logic [CNT_W-1:0]  ae_thresh_i;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;
  logic [CNT_W-1:0]  max_count_o;

  sync_fifo_status #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i),
    .push_i(push_i), .push_data_i(push_data_i), .pop_i(pop_i),
    .pop_data_o(pop_data_o), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .max_count_o(max_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue plus the sticky state.
  logic [DATA_W-1:0] exp_q[$];
  bit m_ovf;
  bit m_udf;
  int m_max;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic             clr;
    logic             push;
    logic [DATA_W-1:0] data;
    logic             pop;
    int               cnt;
    int               head;
    int               ovf;
    int               udf;
    int               mx;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit clr, input bit push, input logic [DATA_W-1:0] data,
                            input bit pop);
    int n;
    bit pacc;
    bit racc;
    n = exp_q.size();
    if (clr) begin
      exp_q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_max = 0;
    end else begin
      pacc = push && ((n < DEPTH) || pop);
      racc = pop && (n > 0);
      if (push && n == DEPTH && !pop) m_ovf = 1;
      if (pop && n == 0) m_udf = 1;
      if (racc) void'(exp_q.pop_front());
      if (pacc) exp_q.push_back(data);
      if (exp_q.size() > m_max) m_max = exp_q.size();
    end
  endtask

  // Called at a negedge: drive, let the posedge happen, return at the next negedge.
  task automatic do_cycle(input bit clr, input bit push, input logic [DATA_W-1:0] data,
                          input bit pop);
    clear_i     = clr;
    push_i      = push;
    push_data_i = data;
    pop_i       = pop;
    @(posedge clk);
    model_step(clr, push, data, pop);
    @(negedge clk);
    clear_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_max = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, " count"}, int'(count_o), n);
    chk({tag, " full"}, int'(full_o), (n == DEPTH) ? 1 : 0);
    chk({tag, " empty"}, int'(empty_o), (n == 0) ? 1 : 0);
    chk({tag, " data"}, int'(pop_data_o), (n > 0) ? int'(exp_q[0]) : 0);
    chk({tag, " afull"}, int'(almost_full_o), (n >= int'(af_thresh_i)) ? 1 : 0);
    chk({tag, " aempty"}, int'(almost_empty_o), (n <= int'(ae_thresh_i)) ? 1 : 0);
    chk({tag, " ovf"}, int'(overflow_o), int'(m_ovf));
    chk({tag, " udf"}, int'(underflow_o), int'(m_udf));
    chk({tag, " max"}, int'(max_count_o), WM ? m_max : 0);
  endtask

  initial begin
    int p_push;
    int p_pop;
    reset       = 1'b1;
    clear_i     = 1'b0;
    push_i      = 1'b0;
    push_data_i = '0;
    pop_i       = 1'b0;
    af_thresh_i = 3'd3;
    ae_thresh_i = 3'd1;

    //           clr   push  data   pop   cnt head   ovf udf max
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 'h11, 0, 0, 1};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 'h11, 0, 0, 2};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 'h11, 0, 0, 3};
    tbl[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 'h11, 0, 0, 4};
    tbl[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 'h11, 1, 0, 4};
    tbl[5]  = '{1'b0, 1'b1, 8'h66, 1'b1, 4, 'h22, 1, 0, 4};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 'h33, 1, 0, 4};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 'h44, 1, 0, 4};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 'h66, 1, 0, 4};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 'h00, 1, 0, 4};
    tbl[10] = '{1'b0, 1'b1, 8'h77, 1'b1, 1, 'h77, 1, 1, 4};
    tbl[11] = '{1'b0, 1'b1, 8'h88, 1'b0, 2, 'h77, 1, 1, 4};
    tbl[12] = '{1'b1, 1'b1, 8'h99, 1'b0, 0, 'h00, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1, 'hA5, 0, 0, 1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 'h00, 0, 0, 1};

    @(negedge clk);
    do_reset();
    chk("reset count", int'(count_o), 0);
    chk("reset empty", int'(empty_o), 1);
    chk("reset full", int'(full_o), 0);
    chk("reset data", int'(pop_data_o), 0);
    chk("reset ovf", int'(overflow_o), 0);
    chk("reset udf", int'(underflow_o), 0);
    chk("reset max", int'(max_count_o), 0);

    // Directed table; the popped value is visible on pop_data_o before the edge.
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pop && !tbl[i].clr && i >= 5 && i <= 8) begin
        chk($sformatf("vec%0d popped", i), int'(pop_data_o),
            (i == 5) ? 'h11 : (i == 6) ? 'h22 : (i == 7) ? 'h33 : 'h44);
      end
      if (i == 12) chk("max before clear", int'(max_count_o), WM ? 4 : 0);
      do_cycle(tbl[i].clr, tbl[i].push, tbl[i].data, tbl[i].pop);
      chk($sformatf("vec%0d count", i), int'(count_o), tbl[i].cnt);
      chk($sformatf("vec%0d head", i), int'(pop_data_o), tbl[i].head);
      chk($sformatf("vec%0d full", i), int'(full_o), (tbl[i].cnt == DEPTH) ? 1 : 0);
      chk($sformatf("vec%0d empty", i), int'(empty_o), (tbl[i].cnt == 0) ? 1 : 0);
      chk($sformatf("vec%0d ovf", i), int'(overflow_o), tbl[i].ovf);
      chk($sformatf("vec%0d udf", i), int'(underflow_o), tbl[i].udf);
      chk($sformatf("vec%0d max", i), int'(max_count_o), WM ? tbl[i].mx : 0);
    end

    // Thresholds at each occupancy, including an unreachable almost-full level.
    af_thresh_i = 3'd3;
    ae_thresh_i = 3'd1;
    #1;
    chk("thr c0 af", int'(almost_full_o), 0);
    chk("thr c0 ae", int'(almost_empty_o), 1);
    do_cycle(1'b0, 1'b1, 8'hC1, 1'b0);
    chk("thr c1 af", int'(almost_full_o), 0);
    chk("thr c1 ae", int'(almost_empty_o), 1);
    do_cycle(1'b0, 1'b1, 8'hC2, 1'b0);
    chk("thr c2 af", int'(almost_full_o), 0);
    chk("thr c2 ae", int'(almost_empty_o), 0);
    do_cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    chk("thr c3 af", int'(almost_full_o), 1);
    chk("thr c3 ae", int'(almost_empty_o), 0);
    do_cycle(1'b0, 1'b1, 8'hC4, 1'b0);
    af_thresh_i = 3'd5;
    #1;
    chk("thr c4 af5", int'(almost_full_o), 0);
    chk("thr c4 full", int'(full_o), 1);
    af_thresh_i = 3'd4;
    #1;
    chk("thr c4 af4", int'(almost_full_o), 1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_model("drain");

    // Many wraps with one entry in flight at a time.
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b0, 1'b1, 8'(i * 7 + 3), 1'b0);
      chk($sformatf("wrap%0d head", i), int'(pop_data_o), (i * 7 + 3) & 8'hFF);
      do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check_model("wraps");

    // Random traffic with a drifting push/pop bias to visit full and empty often.
    p_push = 50;
    p_pop  = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        p_push = $urandom_range(20, 90);
        p_pop  = $urandom_range(20, 90);
      end
      af_thresh_i = 3'($urandom_range(0, 7));
      ae_thresh_i = 3'($urandom_range(0, 7));
      do_cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 99) < p_push),
               8'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < p_pop));
      check_model($sformatf("rnd%0d", c));
    end

    do_reset();
    check_model("final reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
